mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory command controller sitting directly downstream of `processor_wrapper`. It consumes the processor's `command`, `inst_addr` and `data_*` request bus and serialises each command onto one single-port synchronous RAM. It returns `ready`, `error`, `data_rdata` and `inst_rdata` to the processor. Before the processor starts, it runs a boot-load phase that streams a program image into RAM and publishes `mem_start` / `mem_start_ready`.

## Interface
Parameters:
- `MEM_WORDS`, 65536: RAM depth in 32-bit words; power of two, ≥ 4.
- `AW`, `$clog2(MEM_WORDS)`: RAM word-address width.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `command` in 3: processor command: 0 none, 1 fetch, 2 data read + fetch, 3 data write + fetch, 4–7 illegal.
- `inst_addr` in 32: instruction byte address; bits [1:0] ignored.
- `data_addr` in 32: data byte address; bits [1:0] ignored.
- `data_wdata` in 32: write data.
- `data_wstrb` in 4: byte-lane write enables.
- `ready` out 1: controller idle; results valid.
- `error` out 2: 0 ok; 1 data address out of range; 2 inst address out of range; 3 illegal command.
- `data_rdata` out 32: data read result.
- `inst_rdata` out 32: fetched instruction.
- `mem_start` out 32: program start byte address.
- `mem_start_ready` out 1: boot load complete; sticky until reset.
- `load_valid` in 1: boot word valid.
- `load_data` in 32: boot word.
- `load_last` in 1: final boot word; qualified by `load_valid`.
- `load_start` in 32: start address; sampled with the last word.
- `load_ready` out 1: high exactly in LOAD state.
- `mem_en` out 1: RAM access enable.
- `mem_we` out 4: RAM byte write enables; nonzero only with `mem_en`.
- `mem_addr` out AW: RAM word address.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data; valid the cycle after a read enable.

## Operation
- States:
  - LOAD: reset state.
  - IDLE
  - DACC: data access.
  - IACC: instruction access.
  - IWAIT: capture instruction.
  - ERR: one-cycle illegal-command response.
- All outputs are registered, except `load_ready`, which is decoded from state.
- Reset values:
  - `ready`, `error`, `data_rdata`, `inst_rdata`, `mem_start`, `mem_start_ready`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - `load_ready` = 1.
  - Internal load counter = 0.
- LOAD:
  - Each cycle with `load_valid` writes `load_data` to word `cnt` (`mem_we`=4'hF) and increments `cnt`.
  - Once `cnt` ≥ `MEM_WORDS`, further words are accepted and dropped (no RAM write); `cnt` saturates.
  - A word with `load_last`=1: `mem_start` ← {`load_start`[31:2],2'b0}, `mem_start_ready` ← 1, next state IDLE, `ready` ← 1.
  - `command` is ignored in LOAD.
- Accept: a cycle with state IDLE, `ready`=1 and `command`≠0. All request inputs are latched and `ready` ← 0.
  - The processor returns `command` to 0 before `ready` next rises.
  - A nonzero `command` while `ready`=1 is always a new request.
- Range check: word index = `addr`[31:2]; in range iff index < `MEM_WORDS`.
- cmd 1: IDLE → IACC → IWAIT → IDLE.
- cmd 2, 3: IDLE → DACC → IACC → IWAIT → IDLE.
  - DACC, cmd 2: read of the data word; `data_rdata` captured from `mem_rdata` in IACC.
  - DACC, cmd 3: write with `mem_we`=`data_wstrb`, `mem_wdata`=`data_wdata`; `data_rdata` ← 0.
  - `data_wstrb`=0 on cmd 3 performs no RAM write and is not an error.
- Data address out of range:
  - DACC drives `mem_en`=0; `data_rdata` ← 0; `error` ← 1.
  - The fetch still proceeds.
- Inst address out of range:
  - IACC drives `mem_en`=0; `inst_rdata` ← 0; `error` ← 2.
  - This code overrides 1 when both addresses are out of range.
- Illegal command (4–7): IDLE → ERR → IDLE; no RAM access; `error` ← 3; data outputs unchanged.
- In IWAIT: `inst_rdata` ← `mem_rdata` (in range); `error` ← final code (0 if no fault); `ready` ← 1.
- `error`, `data_rdata` and `inst_rdata` hold until the next command completes.
- Reset mid-command or mid-load: abort immediately, return to LOAD, all outputs to reset values. RAM contents are not cleared by this block.

## Timing
- Accept at cycle T:
  - `ready`=0 from T+1.
  - cmd 1: `ready`=1 at T+3.
  - cmd 2/3: `ready`=1 at T+4.
  - illegal: `ready`=1 at T+2.
- Results and `error` are valid in the same cycle `ready` rises.
- Load word at cycle L: `mem_en`/`mem_we` asserted at L+1.
- Last word at cycle L: `mem_start_ready`=1 and `ready`=1 at L+1; the earliest accept is L+1.
- One RAM access per cycle; RAM read latency is exactly 1.

## Test plan
- Reset, load 3 words 0x11, 0x22, 0x33 with `load_start`=0x0000_0006 on the last word → RAM[0..2] written; `mem_start`=0x0000_0004 and `mem_start_ready`=1 the cycle after the last word.
- cmd 1, `inst_addr`=0x8 → `ready` low for 2 cycles, then high at T+3 with `inst_rdata`=0x33, `error`=0.
- cmd 3, `data_addr`=0x4, `data_wstrb`=4'b0011, `data_wdata`=0xAABB_CCDD, `inst_addr`=0 → `ready` at T+4; next cmd 2 on `data_addr` 0x4 returns `data_rdata`=0x0000_CCDD, `inst_rdata`=0x11.
- `MEM_WORDS`=16: cmd 2 with `data_addr`=0x40 → `error`=1, `data_rdata`=0, no data `mem_en`, valid `inst_rdata`; with `inst_addr`=0x40 also out of range → `error`=2.
- cmd 5 → `ready` low one cycle, high at T+2 with `error`=3, no `mem_en` pulse.
- Assert `rst` in DACC → next cycle LOAD, `ready`=0, `mem_start_ready`=0, `load_ready`=1, `mem_en`=0.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory command controller: boot-loads a program image into a single-port
// synchronous RAM, then serialises processor fetch / data-read / data-write
// commands onto that RAM and returns results with a ready/error handshake.
module mem_ctrl #(
  parameter int MEM_WORDS = 65536,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    command,
  input  logic [31:0]   inst_addr,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_wdata,
  input  logic [3:0]    data_wstrb,
  output logic          ready,
  output logic [1:0]    error,
  output logic [31:0]   data_rdata,
  output logic [31:0]   inst_rdata,
  output logic [31:0]   mem_start,
  output logic          mem_start_ready,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  input  logic [31:0]   load_start,
  output logic          load_ready,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    IDLE  = 3'd1,
    DACC  = 3'd2,
    IACC  = 3'd3,
    IWAIT = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Load counter is one bit wider than the address so it can sit at MEM_WORDS.
  localparam logic [AW:0] DEPTH = (AW+1)'(MEM_WORDS);

  state_t        state_q;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] iaddr_q;   // latched instruction word index
  logic          iok_q;     // latched instruction address is in range
  logic          rd_q;      // a data read was issued and must be captured
  logic          dacc_q;    // command carries a data access (2 or 3)
  logic [1:0]    err_q;     // final error code of the running command
  logic [31:0]   dres_q;    // data result, published when the command completes

  logic          accept_d;
  logic          dok_d;
  logic          iok_d;
  logic          unused_bits;

  // Word index (byte address bits [31:2]) must be below the RAM depth.
  function automatic logic in_range(input logic [29:0] widx);
    return {3'b000, widx} < 33'(MEM_WORDS);
  endfunction

  assign accept_d    = (state_q == IDLE) && ready && (command != 3'd0);
  assign dok_d       = in_range(data_addr[31:2]);
  assign iok_d       = in_range(inst_addr[31:2]);
  assign load_ready  = (state_q == LOAD);
  assign unused_bits = ^{inst_addr[1:0], data_addr[1:0], load_start[1:0]};

  // Controller FSM: boot load, command sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= LOAD;
      cnt_q           <= '0;
      ready           <= 1'b0;
      error           <= 2'd0;
      data_rdata      <= 32'h0;
      inst_rdata      <= 32'h0;
      mem_start       <= 32'h0;
      mem_start_ready <= 1'b0;
      mem_en          <= 1'b0;
      mem_we          <= 4'h0;
      mem_addr        <= '0;
      mem_wdata       <= 32'h0;
      iok_q           <= 1'b0;
      rd_q            <= 1'b0;
      dacc_q          <= 1'b0;
      err_q           <= 2'd0;
      dres_q          <= 32'h0;
    end else begin
      // RAM strobes are single-cycle pulses unless a state re-asserts them.
      mem_en <= 1'b0;
      mem_we <= 4'h0;
      unique case (state_q)
        LOAD: begin
          if (load_valid) begin
            // Words beyond the RAM depth are consumed but never written.
            if (cnt_q < DEPTH) begin
              mem_en    <= 1'b1;
              mem_we    <= 4'hF;
              mem_addr  <= cnt_q[AW-1:0];
              mem_wdata <= load_data;
              cnt_q     <= cnt_q + 1'b1;
            end
            if (load_last) begin
              mem_start       <= {load_start[31:2], 2'b00};
              mem_start_ready <= 1'b1;
              ready           <= 1'b1;
              state_q         <= IDLE;
            end
          end
        end
        IDLE: begin
          if (accept_d) begin
            ready   <= 1'b0;
            iaddr_q <= inst_addr[AW+1:2];
            iok_q   <= iok_d;
            rd_q    <= 1'b0;
            dres_q  <= 32'h0;
            dacc_q  <= (command == 3'd2) || (command == 3'd3);
            // An out-of-range fetch outranks an out-of-range data access.
            if (!iok_d)
              err_q <= 2'd2;
            else if (((command == 3'd2) || (command == 3'd3)) && !dok_d)
              err_q <= 2'd1;
            else
              err_q <= 2'd0;
            // The first RAM access is launched straight from the request.
            if (command >= 3'd4) begin
              state_q <= ERR;
            end else if (command == 3'd1) begin
              state_q  <= IACC;
              mem_en   <= iok_d;
              mem_addr <= inst_addr[AW+1:2];
            end else begin
              state_q  <= DACC;
              mem_addr <= data_addr[AW+1:2];
              if (command == 3'd2) begin
                mem_en <= dok_d;
                rd_q   <= dok_d;
              end else begin
                mem_en    <= dok_d && (data_wstrb != 4'h0);
                mem_we    <= dok_d ? data_wstrb : 4'h0;
                mem_wdata <= data_wdata;
              end
            end
          end
        end
        DACC: begin
          state_q  <= IACC;
          mem_en   <= iok_q;
          mem_addr <= iaddr_q;
        end
        IACC: begin
          state_q <= IWAIT;
          if (rd_q)
            dres_q <= mem_rdata;
        end
        IWAIT: begin
          state_q    <= IDLE;
          ready      <= 1'b1;
          error      <= err_q;
          inst_rdata <= iok_q ? mem_rdata : 32'h0;
          if (dacc_q)
            data_rdata <= dres_q;
        end
        ERR: begin
          state_q <= IDLE;
          ready   <= 1'b1;
          error   <= 2'd3;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl with a 16-word RAM: boot loads, fetch/read/write
// commands, range faults, illegal commands and reset during a command.
module tb_mem_ctrl;

  localparam int MW = 16;
  localparam int AWT = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     command;
  logic [31:0]    inst_addr;
  logic [31:0]    data_addr;
  logic [31:0]    data_wdata;
  logic [3:0]     data_wstrb;
  logic           ready;
  logic [1:0]     error;
  logic [31:0]    data_rdata;
  logic [31:0]    inst_rdata;
  logic [31:0]    mem_start;
  logic           mem_start_ready;
  logic           load_valid;
  logic [31:0]    load_data;
  logic           load_last;
  logic [31:0]    load_start;
  logic           load_ready;
  logic           mem_en;
  logic [3:0]     mem_we;
  logic [AWT-1:0] mem_addr;
  logic [31:0]    mem_wdata;
  logic [31:0]    mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_ctrl #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .command(command), .inst_addr(inst_addr),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .ready(ready), .error(error), .data_rdata(data_rdata), .inst_rdata(inst_rdata),
    .mem_start(mem_start), .mem_start_ready(mem_start_ready),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_start(load_start), .load_ready(load_ready), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous RAM, read latency 1, byte write enables.
  logic [31:0] ram [MW] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mmem [MW] = '{default: 32'h0};
  logic        m_load = 1'b1, m_ready = 1'b0, m_sr = 1'b0;
  logic [1:0]  m_err = 2'd0, p_err = 2'd0;
  logic [31:0] m_drd = 0, m_ird = 0, m_start = 0, p_drd = 0, p_ird = 0;
  int          m_cnt = 0, m_busy = 0, cyc = 0;
  int          acc_cnt = 0, exp_acc = 0, acc_chk_cyc = -1, wr_cnt = 0;
  logic        acc_valid = 1'b0;
  logic        chk_on = 1'b0;

  always @(posedge clk) begin
    logic dok, iok;
    int   di, ii;
    cyc++;
    if (mem_en === 1'b1) begin
      acc_cnt++;
      if (mem_we != 4'h0) wr_cnt++;
    end
    if (rst) begin
      m_load = 1'b1; m_ready = 1'b0; m_sr = 1'b0; m_err = 2'd0;
      m_drd = 0; m_ird = 0; m_start = 0; m_cnt = 0; m_busy = 0;
    end else if (m_load) begin
      if (load_valid) begin
        if (m_cnt < MW) begin
          mmem[m_cnt] = load_data;
          m_cnt++;
        end
        if (load_last) begin
          m_start = {load_start[31:2], 2'b00};
          m_sr = 1'b1; m_load = 1'b0; m_ready = 1'b1;
        end
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ready = 1'b1; m_err = p_err; m_drd = p_drd; m_ird = p_ird;
        acc_chk_cyc = cyc;
      end
    end else if (m_ready && command != 3'd0) begin
      m_ready = 1'b0;
      acc_cnt = 0;
      di  = int'(data_addr >> 2);
      ii  = int'(inst_addr >> 2);
      dok = (data_addr >> 2) < 32'(MW);
      iok = (inst_addr >> 2) < 32'(MW);
      acc_valid = 1'b1;
      if (command >= 3'd4) begin
        m_busy = 1; p_err = 2'd3; p_drd = m_drd; p_ird = m_ird; exp_acc = 0;
      end else begin
        m_busy  = (command == 3'd1) ? 2 : 3;
        exp_acc = iok ? 1 : 0;
        p_drd   = m_drd;
        if (command == 3'd2) begin
          p_drd = dok ? mmem[di] : 32'h0;
          if (dok) exp_acc++;
        end else if (command == 3'd3) begin
          p_drd = 32'h0;
          if (dok) begin
            for (int b = 0; b < 4; b++)
              if (data_wstrb[b]) mmem[di][8*b +: 8] = data_wdata[8*b +: 8];
            if (data_wstrb != 4'h0) exp_acc++;
            else acc_valid = 1'b0;
          end
        end
        p_ird = iok ? mmem[ii] : 32'h0;
        p_err = !iok ? 2'd2 : ((command != 3'd1 && !dok) ? 2'd1 : 2'd0);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", 32'(ready), 32'(m_ready));
      chk("load_ready", 32'(load_ready), 32'(m_load));
      chk("error", 32'(error), 32'(m_err));
      chk("data_rdata", data_rdata, m_drd);
      chk("inst_rdata", inst_rdata, m_ird);
      chk("mem_start", mem_start, m_start);
      chk("mem_start_ready", 32'(mem_start_ready), 32'(m_sr));
      chk("we_needs_en", 32'(mem_we != 4'h0 && mem_en !== 1'b1), 32'h0);
      if (acc_chk_cyc == cyc && acc_valid)
        chk("ram_accesses", 32'(acc_cnt), 32'(exp_acc));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input int n, input logic [31:0] base, input logic [31:0] inc,
                            input logic [31:0] start);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + 32'(i) * inc;
      load_last  = (i == n - 1);
      load_start = (i == n - 1) ? start : 32'hDEAD_BEEF;
      command    = (i == n - 1) ? 3'd0 : 3'd1;   // ignored while loading
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    command    = 3'd0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] wd, input logic [3:0] ws, input int lat);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    if (ready !== 1'b1) chk("ready_timeout", 32'(ready), 32'h1);
    command = c; inst_addr = ia; data_addr = da; data_wdata = wd; data_wstrb = ws;
    step();
    command = 3'd0;
    for (int k = 1; k <= lat; k++) begin
      if (k < lat) begin
        chk($sformatf("busy_c%0d_k%0d", c, k), 32'(ready), 32'h0);
        step();
      end else begin
        chk($sformatf("done_c%0d_k%0d", c, k), 32'(ready), 32'h1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    rst = 1'b1; command = 3'd0; inst_addr = 0; data_addr = 0; data_wdata = 0;
    data_wstrb = 4'h0; load_valid = 1'b0; load_data = 0; load_last = 1'b0; load_start = 0;
    step();
    step();
    chk_on = 1'b1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_load_ready", 32'(load_ready), 32'h1);
    chk("rst_start_ready", 32'(mem_start_ready), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    rst = 1'b0;

    wr0 = wr_cnt;
    load_image(3, 32'h11, 32'h11, 32'h0000_0006);
    chk("boot_start_ready", 32'(mem_start_ready), 32'h1);
    chk("boot_mem_start", mem_start, 32'h0000_0004);
    chk("boot_ready", 32'(ready), 32'h1);
    chk("boot_load_ready", 32'(load_ready), 32'h0);
    chk("boot_last_en", 32'(mem_en), 32'h1);
    chk("boot_last_we", 32'(mem_we), 32'hF);
    chk("boot_last_addr", 32'(mem_addr), 32'h2);
    chk("boot_last_data", mem_wdata, 32'h33);
    step();
    chk("boot_writes", 32'(wr_cnt - wr0), 32'h3);

    issue(3'd1, 32'h8, 32'h0, 32'h0, 4'h0, 3);
    chk("fetch_inst", inst_rdata, 32'h33);
    chk("fetch_err", 32'(error), 32'h0);

    issue(3'd3, 32'h0, 32'h4, 32'hAABB_CCDD, 4'b0011, 4);
    chk("write_err", 32'(error), 32'h0);
    chk("write_inst", inst_rdata, 32'h11);

    issue(3'd2, 32'h0, 32'h4, 32'h0, 4'h0, 4);
    chk("read_data", data_rdata, 32'h0000_CCDD);
    chk("read_inst", inst_rdata, 32'h11);

    issue(3'd5, 32'h0, 32'h0, 32'h0, 4'h0, 2);
    chk("illegal_err", 32'(error), 32'h3);
    chk("illegal_keep_data", data_rdata, 32'h0000_CCDD);

    issue(3'd2, 32'h4, 32'h40, 32'h0, 4'h0, 4);
    chk("doob_err", 32'(error), 32'h1);
    chk("doob_data", data_rdata, 32'h0);
    chk("doob_inst", inst_rdata, 32'h0000_CCDD);

    issue(3'd2, 32'h40, 32'h40, 32'h0, 4'h0, 4);
    chk("both_oob_err", 32'(error), 32'h2);
    chk("both_oob_inst", inst_rdata, 32'h0);

    issue(3'd3, 32'h3C, 32'h3C, 32'h5A5A_A5A5, 4'hF, 4);
    chk("top_word_fetch", inst_rdata, 32'h5A5A_A5A5);
    issue(3'd2, 32'h8, 32'h3F, 32'h0, 4'h0, 4);
    chk("top_word_read", data_rdata, 32'h5A5A_A5A5);

    issue(3'd3, 32'h4, 32'h8, 32'hFFFF_FFFF, 4'h0, 4);
    issue(3'd2, 32'h8, 32'h8, 32'h0, 4'h0, 4);
    chk("nostrb_data", data_rdata, 32'h33);

    issue(3'd1, 32'h40, 32'h0, 32'h0, 4'h0, 3);
    chk("ioob_err", 32'(error), 32'h2);
    chk("ioob_keep_data", data_rdata, 32'h33);

    // Reset while the controller sits in the data-access state.
    command = 3'd2; data_addr = 32'h0; inst_addr = 32'h0;
    step();
    command = 3'd0;
    chk("pre_rst_busy", 32'(ready), 32'h0);
    rst = 1'b1;
    step();
    chk("abort_ready", 32'(ready), 32'h0);
    chk("abort_start_ready", 32'(mem_start_ready), 32'h0);
    chk("abort_load_ready", 32'(load_ready), 32'h1);
    chk("abort_mem_en", 32'(mem_en), 32'h0);
    rst = 1'b0;

    wr0 = wr_cnt;
    load_image(18, 32'h100, 32'h1, 32'h0000_0102);
    chk("ovf_mem_start", mem_start, 32'h0000_0100);
    chk("ovf_last_dropped", 32'(mem_en), 32'h0);
    step();
    chk("ovf_writes", 32'(wr_cnt - wr0), 32'd16);
    issue(3'd2, 32'h3C, 32'h0, 32'h0, 4'h0, 4);
    chk("ovf_word0", data_rdata, 32'h100);
    chk("ovf_word15", inst_rdata, 32'h10F);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
